// File: rtl/vend_if.sv
// vend_if: coin/select/refund request side and dispense/change/status side of the vending controller
//   master: coin, sel, cancel out; vend_out, change_valid, change_coin, coin_reject,
//           not_enough_cash, sold_out, busy, credit, stock_flat in
//   slave : the controller, directions reversed
interface vend_if #(
    parameter int N_PROD   = 4,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W  = 4
);
    logic [1:0]                coin;
    logic [N_PROD-1:0]         sel;
    logic                      cancel;
    logic [N_PROD-1:0]         vend_out;
    logic                      change_valid;
    logic [1:0]                change_coin;
    logic                      coin_reject;
    logic                      not_enough_cash;
    logic                      sold_out;
    logic                      busy;
    logic [CREDIT_W-1:0]       credit;
    logic [N_PROD*STOCK_W-1:0] stock_flat;
    modport master (
        output coin, sel, cancel,
        input  vend_out, change_valid, change_coin, coin_reject,
               not_enough_cash, sold_out, busy, credit, stock_flat
    );
    modport slave (
        input  coin, sel, cancel,
        output vend_out, change_valid, change_coin, coin_reject,
               not_enough_cash, sold_out, busy, credit, stock_flat
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: N_PROD-product vending controller with per-product price/stock, greedy 25/10/5 change
//   clk, RESET (sync, active high)
//   bus (vend_if.slave): coin/sel/cancel requests in; vend pulse, change coins, reject/cash/sold-out
//                        pulses, busy, credit and per-product stock out (all registered)
//   RESTOCK_EN defined: adds restock / restock_idx, reloading one product to INIT_STOCK when not busy
module vend_ctrl_multi #(
    parameter int N_PROD     = 4,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5,
    parameter int MAX_CREDIT = 200,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICE_VEC = {N_PROD{CREDIT_W'(30)}}
) (
    input logic clk,
    input logic RESET,
`ifdef RESTOCK_EN
    input logic                                       restock,
    input logic [$clog2(N_PROD > 1 ? N_PROD : 2)-1:0] restock_idx,
`endif
    vend_if.slave bus
);
    localparam int IDX_W = $clog2(N_PROD > 1 ? N_PROD : 2);
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
    state_t state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n, cr_now, price, chg_val;
    logic [CREDIT_W:0]   coin_val, sum;
    logic [STOCK_W-1:0]  stock [N_PROD];
    logic [STOCK_W-1:0]  stock_n [N_PROD];
    logic [CREDIT_W-1:0] price_a [N_PROD];
    logic [N_PROD-1:0]   vend_n, vend_q;
    logic [IDX_W-1:0]    sel_idx;
    logic [1:0]          chg_coin_n, chg_coin_q;
    logic chg_valid_n, chg_valid_q, reject_n, reject_q, nec_n, nec_q, so_n, so_q, busy_q;
    logic idle_like, coin_ok;
    for (genvar g = 0; g < N_PROD; g++) begin : g_prod
        assign price_a[g] = PRICE_VEC[g*CREDIT_W +: CREDIT_W];
        assign bus.stock_flat[g*STOCK_W +: STOCK_W] = stock[g];
    end
    always_comb begin
        idle_like = state == IDLE || state == CREDIT;
        coin_val = bus.coin == 2'd3 ? (CREDIT_W+1)'(25) : bus.coin == 2'd2 ? (CREDIT_W+1)'(10) :
                   bus.coin == 2'd1 ? (CREDIT_W+1)'(5) : '0;
        sum = {1'b0, credit} + coin_val;
        coin_ok = idle_like && bus.coin != 2'd0 && sum <= (CREDIT_W+1)'(MAX_CREDIT);
        // a same-cycle coin is credited before the selection is judged
        cr_now = coin_ok ? sum[CREDIT_W-1:0] : credit;
        sel_idx = '0;
        for (int i = N_PROD - 1; i >= 0; i--)
            if (bus.sel[i]) sel_idx = IDX_W'(i);
        price = price_a[sel_idx];
        chg_val = credit >= CREDIT_W'(25) ? CREDIT_W'(25) : credit >= CREDIT_W'(10) ? CREDIT_W'(10) : CREDIT_W'(5);
        state_n = state;
        credit_n = credit;
        stock_n = stock;
        vend_n = '0;
        chg_valid_n = 1'b0;
        chg_coin_n = 2'd0;
        reject_n = bus.coin != 2'd0 && !coin_ok;
        nec_n = 1'b0;
        so_n = 1'b0;
        if (idle_like) begin
            credit_n = cr_now;
            state_n = cr_now == '0 ? IDLE : CREDIT;
            if (bus.cancel) begin
                if (cr_now != '0) state_n = CHANGE;
            end else if (|bus.sel) begin
                if (cr_now < price) nec_n = 1'b1;
                else if (stock[sel_idx] == '0) so_n = 1'b1;
                else begin
                    vend_n[sel_idx] = 1'b1;
                    stock_n[sel_idx] = stock[sel_idx] - STOCK_W'(1);
                    credit_n = cr_now - price;
                    state_n = VEND;
                end
            end
`ifdef RESTOCK_EN
            // applied after the vend so a same-product restock overrides the decrement
            if (restock && 32'(restock_idx) < N_PROD) stock_n[restock_idx] = STOCK_W'(INIT_STOCK);
`endif
        end else if (state == VEND) begin
            state_n = credit != '0 ? CHANGE : IDLE;
        end else begin
            chg_valid_n = 1'b1;
            chg_coin_n = credit >= CREDIT_W'(25) ? 2'd3 : credit >= CREDIT_W'(10) ? 2'd2 : 2'd1;
            credit_n = credit - chg_val;
            state_n = credit_n == '0 ? IDLE : CHANGE;
        end
    end
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
            credit <= '0;
            stock <= '{default: STOCK_W'(INIT_STOCK)};
            vend_q <= '0;
            chg_valid_q <= 1'b0;
            chg_coin_q <= 2'd0;
            reject_q <= 1'b0;
            nec_q <= 1'b0;
            so_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state <= state_n;
            credit <= credit_n;
            stock <= stock_n;
            vend_q <= vend_n;
            chg_valid_q <= chg_valid_n;
            chg_coin_q <= chg_coin_n;
            reject_q <= reject_n;
            nec_q <= nec_n;
            so_q <= so_n;
            busy_q <= state_n == VEND || state_n == CHANGE;
        end
    end
    assign bus.vend_out = vend_q;
    assign bus.change_valid = chg_valid_q;
    assign bus.change_coin = chg_coin_q;
    assign bus.coin_reject = reject_q;
    assign bus.not_enough_cash = nec_q;
    assign bus.sold_out = so_q;
    assign bus.busy = busy_q;
    assign bus.credit = credit;
endmodule
